opl3_axil_intr_slave: RTL

//  AXI4-Lite responder holding the interrupt-controller registers of opl3_fpga (S_AXI_INTR port).

---
 rtl/opl3_axil_intr_slave.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/opl3_axil_intr_slave.sv
`default_nettype none
// ============================================================================
// Module   : opl3_axil_intr_slave
// Purpose  : AXI4-Lite interrupt-controller register block for opl3_fpga.
//            Captures rising edges of the core interrupt sources into sticky
//            status bits, masks them with per-source enables and a global
//            enable, and drives a single registered irq line.
// Ports    : clk, reset (sync, active high)
//            intr_in[NUM_INTR]  - interrupt sources, synchronous to clk
//            AW/W/B channels    - awaddr/awvalid/awready, wdata/wstrb/wvalid/
//                                 wready, bresp/bvalid/bready
//            AR/R channels      - araddr/arvalid/arready, rdata/rresp/rvalid/
//                                 rready
//            irq                - interrupt request, polarity per
//                                 IRQ_ACTIVE_HIGH
// Map      : 0x00 GIE, 0x04 IER, 0x08 ISR (RO), 0x0C IAR (WO), 0x10 IPR (RO)
// Revision : 1.0 - initial release
// ============================================================================
module opl3_axil_intr_slave #(
    parameter int NUM_INTR        = 1,
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 32,
    parameter bit IRQ_ACTIVE_HIGH = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_INTR-1:0]     intr_in,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    irq
);

    // Word indices within the register window
    localparam logic [ADDR_WIDTH-3:0] c_IDX_GIE = (ADDR_WIDTH-2)'(0);
    localparam logic [ADDR_WIDTH-3:0] c_IDX_IER = (ADDR_WIDTH-2)'(1);
    localparam logic [ADDR_WIDTH-3:0] c_IDX_ISR = (ADDR_WIDTH-2)'(2);
    localparam logic [ADDR_WIDTH-3:0] c_IDX_IAR = (ADDR_WIDTH-2)'(3);
    localparam logic [ADDR_WIDTH-3:0] c_IDX_IPR = (ADDR_WIDTH-2)'(4);

    // Write-channel states
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    // Read-channel states
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [0:0]            r_wState;
    logic [0:0]            w_wStateNext;
    logic                  w_wAccept;
    logic [0:0]            r_rState;
    logic [0:0]            w_rStateNext;
    logic                  w_rAccept;

    logic                  r_gie;
    logic [NUM_INTR-1:0]   r_ier;
    logic [NUM_INTR-1:0]   r_isr;
    logic [NUM_INTR-1:0]   r_intrD;
    logic                  r_irqInt;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [DATA_WIDTH-1:0] w_wMask;
    logic [NUM_INTR-1:0]   w_wMaskN;
    logic [NUM_INTR-1:0]   w_wBitsN;
    logic [NUM_INTR-1:0]   w_ierNext;
    logic [NUM_INTR-1:0]   w_iarClr;
    logic [NUM_INTR-1:0]   w_rise;
    logic [ADDR_WIDTH-3:0] w_wIdx;
    logic [ADDR_WIDTH-3:0] w_rIdx;
    logic [DATA_WIDTH-1:0] w_rdMux;
    logic                  w_unused;

    // Byte-lane strobes expanded to a bit mask
    for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_strb
        assign w_wMask[8*b +: 8] = {8{wstrb[b]}};
    end

    assign w_wIdx    = awaddr[ADDR_WIDTH-1:2];
    assign w_rIdx    = araddr[ADDR_WIDTH-1:2];
    assign w_wMaskN  = w_wMask[NUM_INTR-1:0];
    assign w_wBitsN  = wdata[NUM_INTR-1:0] & w_wMaskN;
    assign w_ierNext = (r_ier & ~w_wMaskN) | w_wBitsN;
    assign w_iarClr  = (w_wAccept && (w_wIdx == c_IDX_IAR)) ? w_wBitsN : '0;
    assign w_rise    = intr_in & ~r_intrD;

    // Address LSBs and bits above NUM_INTR carry no state
    assign w_unused  = &{1'b0, awaddr[1:0], araddr[1:0], wdata, w_wMask};

    // ------------------------------------------------------------------
    // Write channel: AW and W are taken together in a single cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wState <= W_IDLE;
        end else begin
            r_wState <= w_wStateNext;
        end
    end

    always_comb begin
        w_wStateNext = r_wState;
        w_wAccept    = 1'b0;
        case (r_wState)
            W_IDLE: begin
                if (awvalid && wvalid) begin
                    w_wAccept    = 1'b1;
                    w_wStateNext = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_wStateNext = W_IDLE;
                end
            end
            default: w_wStateNext = W_IDLE;
        endcase
        // Ready strobes must stay low while reset is held
        if (reset) begin
            w_wAccept = 1'b0;
        end
    end

    assign awready = w_wAccept;
    assign wready  = w_wAccept;
    assign bvalid  = (r_wState == W_RESP);
    assign bresp   = 2'b00;

    // ------------------------------------------------------------------
    // Read channel: one-cycle latency, data held until rready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rState <= R_IDLE;
        end else begin
            r_rState <= w_rStateNext;
        end
    end

    always_comb begin
        w_rStateNext = r_rState;
        w_rAccept    = 1'b0;
        case (r_rState)
            R_IDLE: begin
                if (arvalid) begin
                    w_rAccept    = 1'b1;
                    w_rStateNext = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    w_rStateNext = R_IDLE;
                end
            end
            default: w_rStateNext = R_IDLE;
        endcase
        if (reset) begin
            w_rAccept = 1'b0;
        end
    end

    always_comb begin
        w_rdMux = '0;
        case (w_rIdx)
            c_IDX_GIE: w_rdMux[0]            = r_gie;
            c_IDX_IER: w_rdMux[NUM_INTR-1:0] = r_ier;
            c_IDX_ISR: w_rdMux[NUM_INTR-1:0] = r_isr;
            c_IDX_IPR: w_rdMux[NUM_INTR-1:0] = r_isr & r_ier;
            default:   w_rdMux               = '0;
        endcase
    end

    assign arready = w_rAccept;
    assign rvalid  = (r_rState == R_DATA);
    assign rdata   = r_rdata;
    assign rresp   = 2'b00;

    // ------------------------------------------------------------------
    // Register file, edge capture and irq
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gie    <= 1'b0;
            r_ier    <= '0;
            r_isr    <= '0;
            r_intrD  <= '0;
            r_irqInt <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_intrD  <= intr_in;
            // A fresh rising edge overrides an acknowledge on the same bit
            r_isr    <= (r_isr & ~w_iarClr) | w_rise;
            r_irqInt <= r_gie & (|(r_isr & r_ier));
            if (w_wAccept) begin
                case (w_wIdx)
                    c_IDX_GIE: if (wstrb[0]) r_gie <= wdata[0];
                    c_IDX_IER: r_ier <= w_ierNext;
                    default:   ;
                endcase
            end
            // Sampled before this edge's write lands: reads see old values
            if (w_rAccept) begin
                r_rdata <= w_rdMux;
            end
        end
    end

    if (IRQ_ACTIVE_HIGH) begin : g_irqHigh
        assign irq = r_irqInt;
    end else begin : g_irqLow
        assign irq = ~r_irqInt;
    end

endmodule
`default_nettype wire
